irda_txd: RTL and testbench

- Transmit side of the IrDA serial link; counterpart of the 10-bit receive shift register.
- Accepts a parallel byte and frames it as start(0), 8 data bits LSB first, stop(1).
- Serialises the frame at BAUD_DIV clocks per bit.
- Drives two outputs: a UART-level line (txd) and an IrDA RZI pulse line (ir_out). ir_out carries a PULSE_LEN-clock high pulse at the start of every 0 bit.

---
 rtl/irda_txd.sv | 113 +++++++++++
 tb/tb_irda_txd.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/irda_txd.sv
// IrDA transmitter: frames a byte as start/8 data (LSB first)/stop and drives txd plus an RZI ir_out line.
// Optional macro IRDA_TXD_PARITY_EN inserts an even-parity bit before the stop bit.
module irda_txd #(
  parameter int BAUD_DIV  = 16,
  parameter int PULSE_LEN = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data_in,
  output logic       busy,
  output logic       done,
  output logic       txd,
  output logic       ir_out
);

`ifdef IRDA_TXD_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int BAUD_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state_q, state_d;
  logic [FRAME_BITS-1:0]   sreg_q, sreg_d;
  logic [BAUD_W-1:0]       baud_q, baud_d;
  logic [3:0]              bit_q, bit_d;
  logic                    fin_q, fin_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    txd_q, txd_d;
  logic                    ir_q, ir_d;
  logic [FRAME_BITS-1:0]   frame;

`ifdef IRDA_TXD_PARITY_EN
  assign frame = {1'b1, ^data_in, data_in, 1'b0};
`else
  assign frame = {1'b1, data_in, 1'b0};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      fin_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      txd_q   <= 1'b1;
      ir_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      fin_q   <= fin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      txd_q   <= txd_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    fin_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          sreg_d  = frame;
          baud_d  = '0;
          bit_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (baud_q == BAUD_W'(BAUD_DIV - 1)) begin
          baud_d = '0;
          sreg_d = {1'b1, sreg_q[FRAME_BITS-1:1]};
          bit_d  = bit_q + 4'd1;
          if (bit_q == 4'(FRAME_BITS - 1)) begin
            bit_d   = '0;
            state_d = IDLE;
            fin_d   = 1'b1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the current state, so the line lags acceptance by one clock.
  always_comb begin
    busy_d = (state_q == SEND);
    done_d = fin_q;
    txd_d  = (state_q == SEND) ? sreg_q[0] : 1'b1;
    ir_d   = (state_q == SEND) && !sreg_q[0] && (baud_q < BAUD_W'(PULSE_LEN));
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign txd    = txd_q;
  assign ir_out = ir_q;

endmodule

// File: tb/tb_irda_txd.sv
// Directed bench for irda_txd: per-cycle expected {busy,done,txd,ir_out} is queued at stimulus time and popped on each sample.
module tb_irda_txd;
  localparam int BD = 16;
  localparam int PL = 3;
`ifdef IRDA_TXD_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       busy, done, txd, ir_out;

  int errors = 0;
  int checks = 0;
  logic [3:0] sb_q[$];

  irda_txd #(.BAUD_DIV(BD), .PULSE_LEN(PL)) dut (
    .clk(clk), .reset(reset), .load(load), .data_in(data_in),
    .busy(busy), .done(done), .txd(txd), .ir_out(ir_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  // Expects the accepting edge to have just happened; checks 161 (or 177) sampled cycles.
  task automatic expect_frame(input logic [7:0] d, input int mid_cyc, input logic [7:0] mid_d,
                              input bit chain, input logic [7:0] nxt, input string tag);
    logic [10:0] fb;
    logic [3:0]  exp_v;
    logic        ir_prev;
    int          pulses, exp_pulses;
`ifdef IRDA_TXD_PARITY_EN
    fb = {1'b1, ^d, d, 1'b0};
`else
    fb = {1'b1, 1'b1, d, 1'b0};
`endif
    exp_pulses = 0;
    for (int b = 0; b < FB; b++) begin
      if (!fb[b]) exp_pulses++;
      for (int c = 0; c < BD; c++)
        sb_q.push_back({1'b1, 1'b0, fb[b], (!fb[b] && c < PL)});
    end
    sb_q.push_back(4'b0110);
    data_in = ~d;
    pulses  = 0;
    ir_prev = 1'b0;
    for (int i = 1; i <= FB * BD + 1; i++) begin
      load = 1'b0;
      if (i == mid_cyc) begin
        load = 1'b1;
        data_in = mid_d;
      end
      if (chain && i == FB * BD + 1) begin
        load = 1'b1;
        data_in = nxt;
      end
      tick();
      exp_v = sb_q.pop_front();
      check($sformatf("%s_cyc%0d", tag, i), {busy, done, txd, ir_out}, exp_v);
      if (ir_out && !ir_prev) pulses++;
      ir_prev = ir_out;
    end
    load = 1'b0;
    check({tag, "_pulses"}, pulses, exp_pulses);
    $display("frame %s data=%02h pulses=%0d", tag, d, pulses);
  endtask

  task automatic accept(input logic [7:0] d);
    load = 1'b1;
    data_in = d;
    tick();
    load = 1'b0;
  endtask

  initial begin
    // Reset, then 50 idle cycles.
    tick();
    tick();
    reset = 1'b0;
    check("reset_state", {busy, done, txd, ir_out}, 4'b0010);
    for (int i = 0; i < 50; i++) begin
      tick();
      check("idle", {busy, done, txd, ir_out}, 4'b0010);
    end

    accept(8'hA5);
    expect_frame(8'hA5, 0, 8'h00, 1'b0, 8'h00, "a5");
    tick();
    check("a5_after", {busy, done, txd, ir_out}, 4'b0010);

    accept(8'hFF);
    expect_frame(8'hFF, 0, 8'h00, 1'b0, 8'h00, "ff");
    tick();
    accept(8'h00);
    expect_frame(8'h00, 0, 8'h00, 1'b0, 8'h00, "00");
    tick();

    // Mid-frame load ignored; load sampled on the done edge starts the next frame at once.
    accept(8'h3C);
    expect_frame(8'h3C, 40, 8'hFF, 1'b1, 8'h81, "3c");
    expect_frame(8'h81, 0, 8'h00, 1'b0, 8'h00, "81");
    tick();

    // Reset during bit 4 of 0x55 (a zero bit, so ir_out is mid-pulse).
    accept(8'h55);
    for (int i = 0; i < 4 * BD + 1; i++) tick();
    check("pre_reset_ir", {busy, txd, ir_out}, 3'b101);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_reset", {busy, done, txd, ir_out}, 4'b0010);
    for (int i = 0; i < FB * BD + 10; i++) begin
      tick();
      check("post_reset_idle", {busy, done, txd, ir_out}, 4'b0010);
    end
    accept(8'h55);
    expect_frame(8'h55, 0, 8'h00, 1'b0, 8'h00, "55");
    tick();

    // load together with reset: reset wins.
    reset = 1'b1;
    load = 1'b1;
    data_in = 8'h12;
    tick();
    reset = 1'b0;
    load = 1'b0;
    tick();
    check("load_with_reset", {busy, done, txd, ir_out}, 4'b0010);

`ifdef IRDA_TXD_PARITY_EN
    tick();
    accept(8'h07);
    expect_frame(8'h07, 0, 8'h00, 1'b0, 8'h00, "par07");
`endif

    check("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
